// File: rtl/aes_pkg.sv
// Shared constants for the AES datapath controllers (input and output side).
package aes_pkg;

   localparam int BLK_W = 128;

   localparam int MODE_ECB = 0;
   localparam int MODE_CTR = 1;
   localparam int MODE_CBC = 2;

   localparam int OP_ENC = 0;
   localparam int OP_DEC = 1;

   // The side operand is folded in for CTR (both directions) and for CBC decrypt.
   function automatic bit uses_side_xor(input int mode, input int op);
      return (mode == MODE_CTR) || ((mode == MODE_CBC) && (op == OP_DEC));
   endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data presents the head entry whenever !empty.
// Shared by the input and output controllers of the AES datapath.
module aes_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_rd   = rd_en && !empty;
   // A write into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage carries no reset; an entry is only visible once pointers and count say it was written.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/aes_out_ctrl_intel.sv
// Output controller of the AES datapath: mode post-combination, result FIFO with
// valid/ready, and CBC-encrypt feedback IV back to the input controller.
module aes_out_ctrl_intel
   import aes_pkg::*;
#(
   parameter int N_PIPES     = 4,
   parameter int MODE        = 0,
   parameter int OPERATION   = 0,
   parameter int FIFO_DEPTH  = 16,
   parameter int PROG_MARGIN = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ivalid,
   input  logic [N_PIPES*BLK_W-1:0]   idata,
   input  logic [N_PIPES*BLK_W-1:0]   iside,
   input  logic [N_PIPES*16-1:0]      ikeep,
   input  logic                       ilast,
   output logic                       oprog_full,
   output logic [BLK_W-1:0]           ofeedbackiv,
   output logic                       ofeedbackvalid,
   output logic [N_PIPES*BLK_W-1:0]   odata,
   output logic [N_PIPES*16-1:0]      okeep,
   output logic                       olast,
   output logic                       ovalid,
   input  logic                       iready,
   output logic                       odone,
   output logic [31:0]                obeats,
   output logic                       oerr_overflow
);

   localparam int DW = N_PIPES*BLK_W;
   localparam int KW = N_PIPES*16;
   localparam int EW = DW + KW + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] PROG_THR = CW'(FIFO_DEPTH - PROG_MARGIN);
   localparam bit XOR_SIDE = uses_side_xor(MODE, OPERATION);
   localparam bit CBC_ENC  = (MODE == MODE_CBC) && (OPERATION == OP_ENC);

   logic          s1_valid;
   logic [DW-1:0] s1_data;
   logic [KW-1:0] s1_keep;
   logic          s1_last;

   logic [EW-1:0] head;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          rd;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid       <= 1'b0;
         ofeedbackvalid <= 1'b0;
         ofeedbackiv    <= '0;
      end else begin
         s1_valid       <= ivalid;
         ofeedbackvalid <= CBC_ENC && ivalid;
         if (CBC_ENC && ivalid) ofeedbackiv <= idata[DW-1 -: BLK_W];
      end
   end

   // Payload is qualified by s1_valid, so it is left out of the reset.
   always_ff @(posedge clk) begin
      if (ivalid) begin
         s1_data <= XOR_SIDE ? (idata ^ iside) : idata;
         s1_keep <= ikeep;
         s1_last <= ilast;
      end
   end

   aes_sync_fifo #(
      .WIDTH(EW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .wr_en  (s1_valid),
      .wr_data({s1_data, s1_keep, s1_last}),
      .rd_en  (rd),
      .rd_data(head),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .count  (fifo_count)
   );

   assign ovalid = !fifo_empty;
   assign rd     = ovalid && iready;
   // Head storage is undefined while empty; present zeros instead.
   assign odata  = fifo_empty ? '0   : head[EW-1 -: DW];
   assign okeep  = fifo_empty ? '0   : head[KW:1];
   assign olast  = fifo_empty ? 1'b0 : head[0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         obeats        <= '0;
         odone         <= 1'b0;
         oerr_overflow <= 1'b0;
         oprog_full    <= 1'b0;
      end else begin
         if (rd) obeats <= obeats + 32'd1;
         odone      <= rd && olast;
         oprog_full <= (fifo_count >= PROG_THR);
         if (s1_valid && fifo_full && !rd) oerr_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_out_ctrl_intel.sv
// Scoreboard bench for aes_out_ctrl_intel: four instances (ECB, CTR, CBC enc, CBC dec)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_aes_out_ctrl_intel;
   import aes_pkg::*;

   localparam int NP     = 4;
   localparam int DW     = NP*BLK_W;
   localparam int KW     = NP*16;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 4;
   localparam int NI     = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          ivalid = 1'b0;
   logic [DW-1:0] idata = '0;
   logic [DW-1:0] iside = '0;
   logic [KW-1:0] ikeep = '0;
   logic          ilast = 1'b0;
   logic          iready = 1'b0;

   logic             oprog_full     [NI];
   logic [BLK_W-1:0] ofeedbackiv    [NI];
   logic             ofeedbackvalid [NI];
   logic [DW-1:0]    odata          [NI];
   logic [KW-1:0]    okeep          [NI];
   logic             olast          [NI];
   logic             ovalid         [NI];
   logic             odone          [NI];
   logic [31:0]      obeats         [NI];
   logic             oerr_overflow  [NI];

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes_out_ctrl_intel #(
         .N_PIPES    (NP),
         .MODE       (g == 0 ? MODE_ECB : (g == 1 ? MODE_CTR : MODE_CBC)),
         .OPERATION  (g == 3 ? OP_DEC : OP_ENC),
         .FIFO_DEPTH (DEPTH),
         .PROG_MARGIN(MARGIN)
      ) u_dut (
         .clk           (clk),
         .resetn        (resetn),
         .ivalid        (ivalid),
         .idata         (idata),
         .iside         (iside),
         .ikeep         (ikeep),
         .ilast         (ilast),
         .oprog_full    (oprog_full[g]),
         .ofeedbackiv   (ofeedbackiv[g]),
         .ofeedbackvalid(ofeedbackvalid[g]),
         .odata         (odata[g]),
         .okeep         (okeep[g]),
         .olast         (olast[g]),
         .ovalid        (ovalid[g]),
         .iready        (iready),
         .odone         (odone[g]),
         .obeats        (obeats[g]),
         .oerr_overflow (oerr_overflow[g])
      );
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected result per instance: 0=ECB, 1=CTR, 2=CBC enc, 3=CBC dec.
   function automatic logic [DW-1:0] ref_data(input int inst, input logic [DW-1:0] d,
                                              input logic [DW-1:0] s);
      if (inst == 1 || inst == 3) return d ^ s;
      return d;
   endfunction

   // ---------------- reference model ----------------
   beat_t            exp_q [NI][$];
   bit               m_last_q[$];
   beat_t            s1_b [NI];
   bit               s1_v = 1'b0;
   bit               m_prog = 1'b0;
   bit               m_done = 1'b0;
   bit               m_ovf = 1'b0;
   bit               m_fbv = 1'b0;
   bit               m_rst = 1'b1;
   logic [31:0]      m_beats = '0;
   logic [BLK_W-1:0] m_fbiv = '0;

   always @(posedge clk) begin
      bit rd;
      bit acc;
      if (!resetn) begin
         s1_v    = 1'b0;
         m_prog  = 1'b0;
         m_done  = 1'b0;
         m_ovf   = 1'b0;
         m_fbv   = 1'b0;
         m_fbiv  = '0;
         m_beats = '0;
         m_rst   = 1'b1;
         m_last_q.delete();
         for (int i = 0; i < NI; i++) exp_q[i].delete();
      end else begin
         m_rst  = 1'b0;
         rd     = (m_last_q.size() > 0) && iready;
         m_prog = (m_last_q.size() >= DEPTH - MARGIN);
         acc    = s1_v && ((m_last_q.size() < DEPTH) || rd);
         if (s1_v && !acc) m_ovf = 1'b1;
         m_done = 1'b0;
         if (rd) begin
            m_done  = m_last_q.pop_front();
            m_beats = m_beats + 32'd1;
         end
         if (acc) begin
            m_last_q.push_back(s1_b[0].last);
            for (int i = 0; i < NI; i++) exp_q[i].push_back(s1_b[i]);
         end
         m_fbv = ivalid;
         if (ivalid) m_fbiv = idata[DW-1 -: BLK_W];
         s1_v = ivalid;
         for (int i = 0; i < NI; i++) begin
            s1_b[i].data = ref_data(i, idata, iside);
            s1_b[i].keep = ikeep;
            s1_b[i].last = ilast;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.ovalid", i), DW'(ovalid[i]), DW'(m_last_q.size() > 0));
            check($sformatf("u%0d.oprog_full", i), DW'(oprog_full[i]), DW'(m_prog));
            check($sformatf("u%0d.obeats", i), DW'(obeats[i]), DW'(m_beats));
            check($sformatf("u%0d.odone", i), DW'(odone[i]), DW'(m_done));
            check($sformatf("u%0d.oerr_overflow", i), DW'(oerr_overflow[i]), DW'(m_ovf));
            check($sformatf("u%0d.ofeedbackvalid", i), DW'(ofeedbackvalid[i]),
                  DW'((i == 2) && m_fbv));
            check($sformatf("u%0d.ofeedbackiv", i), DW'(ofeedbackiv[i]),
                  (i == 2) ? DW'(m_fbiv) : '0);
            if (m_rst) begin
               check($sformatf("u%0d.odata_rst", i), odata[i], '0);
               check($sformatf("u%0d.okeep_rst", i), DW'(okeep[i]), '0);
               check($sformatf("u%0d.olast_rst", i), DW'(olast[i]), '0);
            end
            if (ovalid[i] && iready && resetn) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("u%0d.unexpected_beat", i), DW'(1), DW'(0));
               end else begin
                  beat_t e;
                  e = exp_q[i].pop_front();
                  check($sformatf("u%0d.odata", i), odata[i], e.data);
                  check($sformatf("u%0d.okeep", i), DW'(okeep[i]), DW'(e.keep));
                  check($sformatf("u%0d.olast", i), DW'(olast[i]), DW'(e.last));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] s,
                       input logic [KW-1:0] k, input logic l);
      ivalid = 1'b1;
      idata  = d;
      iside  = s;
      ikeep  = k;
      ilast  = l;
      step();
   endtask

   task automatic idle(input int n);
      ivalid = 1'b0;
      ilast  = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_reset();
      ivalid = 1'b0;
      resetn = 1'b0;
      step();
      resetn = 1'b1;
   endtask

   function automatic logic [DW-1:0] rand_blk();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      logic [7:0]       b8;
      logic [BLK_W-1:0] lane3;
      logic [DW-1:0]    d;

      resetn = 1'b0;
      step();
      mon_en = 1'b1;
      step();
      resetn = 1'b1;
      step();

      // ECB-style 3-beat message, ready held high.
      iready = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         b8 = 8'(b);
         send({(DW/8){b8}}, rand_blk(), '1, b == 3);
      end
      idle(6);
      check("ecb_obeats", DW'(obeats[0]), DW'(3));
      check("ecb_drained", DW'(exp_q[0].size()), DW'(0));

      // CTR: A5 ^ 5A gives all ones.
      send({(DW/8){8'hA5}}, {(DW/8){8'h5A}}, '1, 1'b1);
      idle(5);

      // CBC encrypt feedback capture, one cycle after ivalid.
      lane3 = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
      d = rand_blk();
      d[DW-1 -: BLK_W] = lane3;
      send(d, rand_blk(), '1, 1'b1);
      check("cbc_fbvalid", DW'(ofeedbackvalid[2]), DW'(1));
      check("cbc_fbiv", DW'(ofeedbackiv[2]), DW'(lane3));
      idle(5);

      // Overflow: 20 beats into a stalled 16-entry FIFO.
      do_reset();
      iready = 1'b0;
      for (int b = 0; b < 20; b++) send(rand_blk(), rand_blk(), KW'($urandom), b == 19);
      idle(3);
      check("ovf_flag", DW'(oerr_overflow[0]), DW'(1));
      check("ovf_prog_full", DW'(oprog_full[0]), DW'(1));
      iready = 1'b1;
      idle(22);
      check("ovf_delivered", DW'(obeats[0]), DW'(16));

      // Full FIFO with simultaneous write and read.
      do_reset();
      iready = 1'b0;
      for (int b = 0; b < 17; b++) send(rand_blk(), rand_blk(), KW'($urandom), b == 16);
      ivalid = 1'b0;
      iready = 1'b1;
      step();
      iready = 1'b0;
      idle(2);
      check("full_rw_no_ovf", DW'(oerr_overflow[1]), DW'(0));
      check("full_rw_prog", DW'(oprog_full[1]), DW'(1));
      iready = 1'b1;
      idle(22);
      check("full_rw_delivered", DW'(obeats[1]), DW'(17));

      // Reset mid-message with 5 beats buffered.
      iready = 1'b0;
      for (int b = 0; b < 5; b++) send(rand_blk(), rand_blk(), '1, 1'b0);
      idle(2);
      do_reset();
      check("rst_ovalid", DW'(ovalid[3]), DW'(0));
      check("rst_obeats", DW'(obeats[3]), DW'(0));
      check("rst_ovf", DW'(oerr_overflow[3]), DW'(0));
      iready = 1'b1;
      for (int b = 0; b < 3; b++) send(rand_blk(), rand_blk(), '1, b == 2);
      idle(6);
      check("post_rst_obeats", DW'(obeats[3]), DW'(3));

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 500; c++) begin
         iready = ($urandom_range(2) != 0);
         if (($urandom_range(3) != 0) && (!m_prog || $urandom_range(40) == 0))
            send(rand_blk(), rand_blk(), KW'($urandom), $urandom_range(3) == 0);
         else
            idle(1);
      end
      iready = 1'b1;
      idle(30);
      for (int i = 0; i < NI; i++)
         check($sformatf("u%0d.final_drained", i), DW'(exp_q[i].size()), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
